// File: rtl/spi_byte_tx.sv
// SPI mode-0 master for single bytes fed by the serial receiver, with a one-byte holding buffer.
// Frame: CS_N low for 18*CLK_DIV cycles, MSB first; a LOAD arriving with the buffer full is dropped and flagged.
module spi_byte_tx #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOAD,
  input  logic [7:0] BYTEIN,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS_N,
  output logic       BUSY,
  output logic       FULL,
  output logic       DONE,
  output logic       OVERRUN
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       edge_q, edge_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       buf_q, buf_d;
  logic             full_d, sclk_d, mosi_d, cs_n_d, busy_d, done_d, ovr_d;
  logic             consume;
  logic             half_end;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    edge_d   = edge_q;
    shift_d  = shift_q;
    buf_d    = buf_q;
    full_d   = FULL;
    sclk_d   = SCLK;
    mosi_d   = MOSI;
    cs_n_d   = CS_N;
    done_d   = 1'b0;
    ovr_d    = 1'b0;
    consume  = (state_q == IDLE) && FULL;
    half_end = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (FULL) begin
          shift_d = buf_q;
          mosi_d  = buf_q[7];
          cs_n_d  = 1'b0;
          div_d   = '0;
          edge_d  = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        div_d = half_end ? '0 : div_q + 1'b1;
        if (half_end) state_d = SHIFT;
      end
      SHIFT: begin
        div_d = half_end ? '0 : div_q + 1'b1;
        if (half_end) begin
          edge_d = edge_q + 4'd1;
          // even edge_q -> rising toggle; odd edge_q -> falling toggle
          if (!edge_q[0]) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (edge_q == 4'd15) begin
              state_d = HOLD;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              mosi_d  = shift_q[6];
            end
          end
        end
      end
      HOLD: begin
        div_d = half_end ? '0 : div_q + 1'b1;
        if (half_end) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        div_d = half_end ? '0 : div_q + 1'b1;
        if (half_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a consume frees the slot in the same cycle, so a coincident LOAD is not an overrun
    if (LOAD) begin
      if (!FULL || consume) begin
        buf_d  = BYTEIN;
        full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (consume) begin
      full_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      buf_q   <= '0;
      FULL    <= 1'b0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      CS_N    <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      FULL    <= full_d;
      SCLK    <= sclk_d;
      MOSI    <= mosi_d;
      CS_N    <= cs_n_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
      OVERRUN <= ovr_d;
    end
  end

endmodule
